capture_sequencer: RTL and testbench
====================================

Name: capture_sequencer

Overview:
- Controls acquisition of ADC samples into a two-bank, 160-entry sample RAM for the VGA waveform display.
- Arms the capture and detects a level/edge trigger on the sample stream.
- Sequences the write addresses 0..159, then swaps the write and display banks at a frame boundary so the display never reads a half-filled bank.
- Sits between the ADC sample stream, already strobed into the clk domain, and the sample RAM / VGA read path.

Parameters:
DEPTH, 160, samples per capture; last write address is DEPTH-1
AW, 8, address width
DW, 8, sample width
HOLDOFF, 4, valid samples consumed after arming before a trigger may be accepted
AUTO_TIMEOUT, 16'd50000, valid samples in WAIT_TRIG before a forced (auto) trigger

Ports:
clk  in  1  system clock, all logic on the rising edge
reset  in  1  asynchronous, active-low reset
sample_valid  in  1  one-cycle strobe: adc_data holds a new sample
adc_data  in  DW  ADC sample
run  in  1  level: continuous re-arm after each capture
single  in  1  one-cycle pulse: arm one capture (honoured in IDLE only)
trig_level  in  DW  trigger threshold
trig_rising  in  1  1 = rising-edge trigger, 0 = falling-edge trigger
auto_en  in  1  enable the auto-trigger timeout
frame_start  in  1  one-cycle VGA frame-boundary pulse (vsync), clk domain
wr_en  out  1  sample RAM write strobe
wr_addr  out  AW  sample RAM write address
wr_data  out  DW  sample RAM write data
wr_bank  out  1  bank currently being written
rd_bank  out  1  bank the display reads
capture_done  out  1  one-cycle pulse at the bank swap
auto_trig  out  1  last completed capture was auto-triggered
state  out  3  current FSM state, for debug

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, wr_en=0, wr_addr=0, wr_data=0, wr_bank=0, rd_bank=1, capture_done=0, auto_trig=0. All counters and the previous-sample register are cleared, and prev_valid=0.
- Reset asserted mid-capture: capture is aborted and the banks return to their reset values. Partial bank contents are don't-care.
- States: IDLE=0, ARM=1, WAIT_TRIG=2, CAPTURE=3, DONE=4.
- IDLE -> ARM when run=1 or single=1. If both are high, enter ARM once; run then governs re-arming.
- On entry to ARM: holdoff counter=0 and prev_valid=0.
- ARM: each sample_valid loads prev and sets prev_valid. After HOLDOFF valid samples -> WAIT_TRIG.
- Trigger, evaluated only on sample_valid in WAIT_TRIG with prev_valid=1:
  - rising: prev < trig_level and adc_data >= trig_level
  - falling: prev > trig_level and adc_data <= trig_level
  - comparisons are unsigned
  - prev updates on every valid sample
- Auto trigger: the timeout counter counts valid samples in WAIT_TRIG and is cleared on entry. If auto_en=1 and the counter has reached AUTO_TIMEOUT, the next valid sample triggers unconditionally and sets the pending auto flag. A real trigger on that same sample takes priority and the flag stays clear.
- The triggering sample is written at address 0. The FSM enters CAPTURE with address counter=1.
- CAPTURE: each sample_valid writes at the counter value and increments it. The write of address DEPTH-1 moves the FSM to DONE; the counter never exceeds DEPTH-1.
- Write timing (1-cycle latency): wr_en, wr_addr and wr_data are registered and appear one cycle after the accepted sample_valid. wr_en is high for exactly one cycle per written sample. Exactly DEPTH writes occur per capture.
- DONE: samples are ignored. Only a frame_start seen while already in DONE counts; a pulse in the same cycle the FSM enters DONE is ignored. On a counted frame_start:
  - rd_bank<=wr_bank and wr_bank<=~wr_bank
  - capture_done=1 for one cycle
  - auto_trig<=pending auto flag
  - next state ARM if run=1, else IDLE
- run deasserted mid-capture does not abort; the capture completes and the FSM returns to IDLE. single is ignored outside IDLE.
- wr_bank != rd_bank at all times after reset.

Test Plan:
- Reset, run=1, trig_rising=1, trig_level=128, ramp 0..255 on every 4th clk -> after 4 holdoff samples, trigger on sample value 128. Writes addr 0..159 carry data 128..255, 0..31, 160 wr_en pulses total. At the next frame_start: capture_done=1, rd_bank=0, wr_bank=1.
- Falling trigger, trig_level=100, sine crossing downward -> addr 0 data is the first sample <=100 after a sample >100. auto_trig=0.
- auto_en=1, AUTO_TIMEOUT=20, constant input 50, trig_level=128 -> forced trigger on the 21st valid sample in WAIT_TRIG. auto_trig=1 after the swap.
- single pulse with run=0 -> exactly one capture and one swap, then state=IDLE. A second single pulse during CAPTURE is ignored.
- frame_start in the same cycle as the last write, then another 10 clks later -> no swap on the first pulse, swap on the second.
- reset pulsed low at capture address 73 -> outputs immediately at reset values, wr_bank=0, rd_bank=1, state=IDLE.

Source files
------------

// File: rtl/capture_sequencer.sv
// capture_sequencer: arms, triggers and sequences writes of ADC samples
// into a two-bank sample RAM; swaps banks on a VGA frame boundary.
//
// Ports:
//   clk, reset (async, active-low)
//   sample_valid/adc_data        : sample stream, already in clk domain
//   run/single                   : continuous re-arm / one-shot arm
//   trig_level/trig_rising       : edge trigger threshold and polarity
//   auto_en                      : forced trigger after AUTO_TIMEOUT samples
//   frame_start                  : vsync pulse, bank swap point
//   wr_en/wr_addr/wr_data        : registered sample RAM write port
//   wr_bank/rd_bank              : bank being written / bank displayed
//   capture_done/auto_trig/state : status
`timescale 1ns/1ps

module capture_sequencer #(
  parameter int          DEPTH        = 160,
  parameter int          AW           = 8,
  parameter int          DW           = 8,
  parameter int          HOLDOFF      = 4,
  parameter logic [15:0] AUTO_TIMEOUT = 16'd50000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          sample_valid,
  input  logic [DW-1:0] adc_data,
  input  logic          run,
  input  logic          single,
  input  logic [DW-1:0] trig_level,
  input  logic          trig_rising,
  input  logic          auto_en,
  input  logic          frame_start,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  output logic          wr_bank,
  output logic          rd_bank,
  output logic          capture_done,
  output logic          auto_trig,
  output logic [2:0]    state
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ARM       = 3'd1,
    WAIT_TRIG = 3'd2,
    CAPTURE   = 3'd3,
    DONE      = 3'd4
  } state_t;

  localparam int            HW    = $clog2(HOLDOFF + 1);
  localparam logic [HW-1:0] HLAST = HW'(HOLDOFF - 1);
  localparam logic [AW-1:0] LAST  = AW'(DEPTH - 1);

  state_t          state_q;
  state_t          state_d;

  logic [HW-1:0]   hcnt;
  logic [15:0]     tcnt;
  logic [AW-1:0]   acnt;
  logic [DW-1:0]   prev;
  logic            prev_valid;
  logic            pend_auto;
  logic            done_seen;

  logic            rise_hit;
  logic            fall_hit;
  logic            tmo_hit;

  logic            arm_entry;
  logic            trig_real;
  logic            trig_auto;
  logic            wr_fire;
  logic [AW-1:0]   wr_addr_d;
  logic            swap;

  assign state = state_q;

  assign rise_hit = (prev < trig_level) &&
                    (adc_data >= trig_level);
  assign fall_hit = (prev > trig_level) &&
                    (adc_data <= trig_level);
  // tcnt saturates at AUTO_TIMEOUT, so equality means "reached"
  assign tmo_hit  = auto_en && (tcnt == AUTO_TIMEOUT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    arm_entry = 1'b0;
    trig_real = 1'b0;
    trig_auto = 1'b0;
    wr_fire   = 1'b0;
    wr_addr_d = acnt;
    swap      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (run || single) begin
          state_d   = ARM;
          arm_entry = 1'b1;
        end
      end
      ARM: begin
        if (sample_valid && (hcnt == HLAST))
          state_d = WAIT_TRIG;
      end
      WAIT_TRIG: begin
        if (sample_valid) begin
          trig_real = prev_valid &&
                      (trig_rising ? rise_hit : fall_hit);
          trig_auto = tmo_hit;
          if (trig_real || trig_auto) begin
            state_d   = CAPTURE;
            wr_fire   = 1'b1;
            wr_addr_d = '0;
          end
        end
      end
      CAPTURE: begin
        if (sample_valid) begin
          wr_fire = 1'b1;
          if (acnt == LAST) state_d = DONE;
        end
      end
      DONE: begin
        // done_seen masks a vsync arriving on the DONE entry cycle
        if (done_seen && frame_start) begin
          swap      = 1'b1;
          state_d   = run ? ARM : IDLE;
          arm_entry = run;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      wr_bank      <= 1'b0;
      rd_bank      <= 1'b1;
      capture_done <= 1'b0;
      auto_trig    <= 1'b0;
      hcnt         <= '0;
      tcnt         <= '0;
      acnt         <= '0;
      prev         <= '0;
      prev_valid   <= 1'b0;
      pend_auto    <= 1'b0;
      done_seen    <= 1'b0;
    end else begin
      wr_en        <= wr_fire;
      capture_done <= swap;
      done_seen    <= (state_q == DONE) &&
                      (state_d == DONE);

      if (wr_fire) begin
        wr_addr <= wr_addr_d;
        wr_data <= adc_data;
      end

      if (arm_entry) begin
        hcnt       <= '0;
        prev_valid <= 1'b0;
      end else if (sample_valid &&
                   (state_q == ARM ||
                    state_q == WAIT_TRIG)) begin
        prev       <= adc_data;
        prev_valid <= 1'b1;
        if (state_q == ARM) hcnt <= hcnt + 1'b1;
      end

      if (state_q == ARM) begin
        tcnt <= '0;
      end else if (state_q == WAIT_TRIG && sample_valid) begin
        if (state_d == CAPTURE) begin
          acnt      <= AW'(1);
          pend_auto <= trig_auto && !trig_real;
        end else if (tcnt != AUTO_TIMEOUT) begin
          tcnt <= tcnt + 16'd1;
        end
      end

      if (state_q == CAPTURE && sample_valid &&
          acnt != LAST)
        acnt <= acnt + 1'b1;

      if (swap) begin
        rd_bank   <= wr_bank;
        wr_bank   <= ~wr_bank;
        auto_trig <= pend_auto;
      end
    end
  end

endmodule

// File: tb/tb_capture_sequencer.sv
// tb_capture_sequencer: randomized scoreboard bench for
// capture_sequencer against a sample-list reference model.
`timescale 1ns/1ps

module tb_capture_sequencer;

  localparam int DEPTH   = 160;
  localparam int HOLDOFF = 4;
  localparam int TMO     = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       sample_valid = 1'b0;
  logic [7:0] adc_data = '0;
  logic       run = 1'b0;
  logic       single = 1'b0;
  logic [7:0] trig_level = '0;
  logic       trig_rising = 1'b1;
  logic       auto_en = 1'b0;
  logic       frame_start = 1'b0;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       wr_bank;
  logic       rd_bank;
  logic       capture_done;
  logic       auto_trig;
  logic [2:0] state;

  capture_sequencer #(
    .DEPTH(DEPTH), .AW(8), .DW(8),
    .HOLDOFF(HOLDOFF), .AUTO_TIMEOUT(16'(TMO))
  ) dut (
    .clk(clk), .reset(reset),
    .sample_valid(sample_valid), .adc_data(adc_data),
    .run(run), .single(single),
    .trig_level(trig_level), .trig_rising(trig_rising),
    .auto_en(auto_en), .frame_start(frame_start),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_bank(wr_bank), .rd_bank(rd_bank),
    .capture_done(capture_done), .auto_trig(auto_trig),
    .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] d;
  } wr_t;

  typedef struct packed {
    logic rd;
    logic wr;
    logic at;
  } sw_t;

  wr_t        wq[$];
  sw_t        sq[$];
  logic [7:0] smp[$];
  int         n_cmp = 0;
  int         n_err = 0;
  int         wcount = 0;
  int         scount = 0;
  logic       mwr = 1'b0;
  wr_t        we;
  sw_t        se;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic miss(input string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s: event with nothing expected", nm);
  endtask

  // Scoreboard monitor: writes and swaps popped in order.
  always @(negedge clk) begin
    if (reset) begin
      if (wr_en) begin
        wcount++;
        if (wq.size() == 0) miss("wr_unexpected");
        else begin
          we = wq.pop_front();
          chk("wr_addr", 32'(wr_addr), 32'(we.a));
          chk("wr_data", 32'(wr_data), 32'(we.d));
        end
      end
      if (capture_done) begin
        scount++;
        if (sq.size() == 0) miss("swap_unexpected");
        else begin
          se = sq.pop_front();
          chk("rd_bank", 32'(rd_bank), 32'(se.rd));
          chk("wr_bank", 32'(wr_bank), 32'(se.wr));
          chk("auto_trig", 32'(auto_trig), 32'(se.at));
        end
      end
      chk("bank_split", 32'(wr_bank ^ rd_bank), 32'd1);
    end
  end

  // Reference: index of the triggering sample counted from arming.
  function automatic int find_trig(input logic [7:0] lvl,
                                   input bit rising,
                                   input bit aen,
                                   output bit is_auto);
    bit hit;
    is_auto = 1'b0;
    for (int i = HOLDOFF; i < smp.size(); i++) begin
      if (rising) hit = smp[i-1] < lvl && smp[i] >= lvl;
      else        hit = smp[i-1] > lvl && smp[i] <= lvl;
      if (hit) return i;
      if (aen && (i - HOLDOFF) >= TMO) begin
        is_auto = 1'b1;
        return i;
      end
    end
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // arm: 0 already armed, 1 single pulse, 2 run level
  task automatic capture(input int arm, input int gap,
                         input logic [7:0] lvl, input bit rising,
                         input bit aen, input int abort_at,
                         input bit late_fs, input bit single_mid,
                         input bit drop_run);
    int t;
    int n;
    int target;
    int starget;
    int g;
    bit at;
    trig_level  = lvl;
    trig_rising = rising;
    auto_en     = aen;
    t = find_trig(lvl, rising, aen, at);
    if (t < 0) begin
      miss("model_no_trigger");
      return;
    end
    n = (abort_at >= 0) ? abort_at + 1 : DEPTH;
    for (int k = 0; k < n; k++)
      wq.push_back(wr_t'{a: 8'(k), d: smp[t+k]});
    target = wcount + n;
    tick();
    if (arm == 1) single = 1'b1;
    if (arm == 2) run = 1'b1;
    tick();
    single = 1'b0;
    for (int i = 0; i < smp.size(); i++) begin
      if (abort_at >= 0 && i > t + abort_at) break;
      g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
      repeat (g) tick();
      sample_valid = 1'b1;
      adc_data     = smp[i];
      tick();
      sample_valid = 1'b0;
      if (single_mid && i == t + 40) begin
        single = 1'b1;
        tick();
        single = 1'b0;
      end
      if (drop_run && i == t + 80) run = 1'b0;
      if (late_fs && i == t + DEPTH - 1) begin
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
      end
    end
    for (int k = 0; k < 4000 && wcount < target; k++)
      @(posedge clk);
    #1;
    chk("write_count", 32'(wcount), 32'(target));
    if (abort_at >= 0) return;
    repeat (late_fs ? 9 : 2) tick();
    sq.push_back(sw_t'{rd: mwr, wr: ~mwr, at: at});
    mwr = ~mwr;
    starget = scount + 1;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    for (int k = 0; k < 50 && scount < starget; k++)
      @(posedge clk);
    #1;
    chk("swap_count", 32'(scount), 32'(starget));
  endtask

  task automatic fill_rand(input int len);
    smp.delete();
    for (int i = 0; i < len; i++)
      smp.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_wr_en"}, 32'(wr_en), 0);
    chk({nm, "_wr_addr"}, 32'(wr_addr), 0);
    chk({nm, "_wr_data"}, 32'(wr_data), 0);
    chk({nm, "_wr_bank"}, 32'(wr_bank), 0);
    chk({nm, "_rd_bank"}, 32'(rd_bank), 1);
    chk({nm, "_done"}, 32'(capture_done), 0);
    chk({nm, "_auto"}, 32'(auto_trig), 0);
    chk({nm, "_state"}, 32'(state), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    real v;
    repeat (3) @(posedge clk);
    #2;
    chk_reset_vals("reset");
    reset = 1'b1;
    mwr   = 1'b0;

    // ramp, rising 128, continuous run
    smp.delete();
    for (int i = 0; i < 128 + DEPTH + 3; i++)
      smp.push_back(8'(i % 256));
    capture(2, 3, 8'd128, 1'b1, 1'b0, -1, 1'b0, 1'b0, 1'b0);
    repeat (2) tick();
    chk("state_rearm", 32'(state), 1);

    // already armed; run dropped mid-capture
    fill_rand(HOLDOFF + TMO + DEPTH + 3);
    capture(0, -1, 8'($urandom_range(0, 255)), 1'($urandom),
            1'b1, -1, 1'b0, 1'b0, 1'b1);
    repeat (2) tick();
    chk("state_after_run_drop", 32'(state), 0);

    // falling-edge sine crossing 100
    smp.delete();
    for (int i = 0; i < 400; i++) begin
      v = 128.0 + 100.0 * $sin(6.2831853 * i / 37.0);
      smp.push_back(8'($rtoi(v)));
    end
    capture(1, -1, 8'd100, 1'b0, 1'b0, -1, 1'b0, 1'b0, 1'b0);

    // flat input: auto trigger after timeout
    smp.delete();
    for (int i = 0; i < HOLDOFF + TMO + DEPTH + 3; i++)
      smp.push_back(8'd50);
    capture(1, -1, 8'd128, 1'b1, 1'b1, -1, 1'b0, 1'b0, 1'b0);

    // single capture with a stray single pulse in CAPTURE
    fill_rand(HOLDOFF + TMO + DEPTH + 3);
    capture(1, -1, 8'($urandom_range(0, 255)), 1'($urandom),
            1'b1, -1, 1'b0, 1'b1, 1'b0);
    repeat (3) tick();
    chk("state_single_idle", 32'(state), 0);

    // vsync on the last-write cycle must not swap
    fill_rand(HOLDOFF + TMO + DEPTH + 3);
    capture(1, -1, 8'($urandom_range(0, 255)), 1'($urandom),
            1'b1, -1, 1'b1, 1'b0, 1'b0);

    for (int r = 0; r < 3; r++) begin
      fill_rand(HOLDOFF + TMO + DEPTH + 3);
      capture(1, -1, 8'($urandom_range(0, 255)), 1'($urandom),
              1'b1, -1, 1'b0, 1'b0, 1'b0);
    end

    // reset in the middle of a capture
    fill_rand(HOLDOFF + TMO + DEPTH + 3);
    capture(1, -1, 8'($urandom_range(0, 255)), 1'($urandom),
            1'b1, 73, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk_reset_vals("abort");
    chk("abort_writes_drained", 32'(wq.size()), 0);
    wq.delete();
    mwr = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b1;

    // capture after abort: banks back at reset values
    fill_rand(HOLDOFF + TMO + DEPTH + 3);
    capture(1, -1, 8'($urandom_range(0, 255)), 1'($urandom),
            1'b1, -1, 1'b0, 1'b0, 1'b0);

    repeat (5) tick();
    chk("wq_drained", 32'(wq.size()), 0);
    chk("sq_drained", 32'(sq.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
